main_memory_model: RTL and testbench

- Block-granular backing memory that sits directly downstream of the cache controller and cache memory.
- Serves write-backs of dirty lines (`write_en_mem` plus `dirty_block_in`) and line refills (`read_en_mem` returning `data_out_mem`).
- Completion of each transfer is signalled with a one-cycle `ready_mem` pulse after a programmable latency.
- Gives the cache a realistic multi-cycle miss penalty for simulation and FPGA bring-up.

---
 rtl/main_memory_model.sv | 113 +++++++++++
 tb/tb_main_memory_model.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/main_memory_model.sv
// main_memory_model: line-granular backing store that answers refills and write-backs with a ready_mem pulse after LATENCY cycles.
// Define MAIN_MEM_STATS_EN to add the rd_count/wr_count completion counters.
module main_memory_model #(
   parameter int BLOCK_SIZE = 128,
   parameter int NUM_LINES  = 256,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_mem,
   input  logic                  write_en_mem,
   input  logic [31:0]           address,
   input  logic [BLOCK_SIZE-1:0] dirty_block_in,
   output logic [BLOCK_SIZE-1:0] data_out_mem,
   output logic                  ready_mem,
   output logic                  busy
`ifdef MAIN_MEM_STATS_EN
   ,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
`endif
);
   localparam int IDX_W = $clog2(NUM_LINES);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT_LOW} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
   logic [BLOCK_SIZE-1:0] data_q, data_d;
   logic                  wr_q, wr_d;
   logic                  commit;
   logic [BLOCK_SIZE-1:0] mem [NUM_LINES] = '{default: '0};
   logic                  unused_addr;

   assign unused_addr = ^{address[31:4+IDX_W], address[3:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: if (read_en_mem || write_en_mem) begin
            idx_d   = address[4 +: IDX_W];
            wdata_d = dirty_block_in;
            wr_d    = write_en_mem;
            cnt_d   = 4'(LATENCY - 1);
            state_d = (LATENCY == 1) ? RESP : BUSY;
         end
         BUSY: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : BUSY;
         end
         RESP:     state_d = WAIT_LOW;
         WAIT_LOW: state_d = (!read_en_mem && !write_en_mem) ? IDLE : WAIT_LOW;
         default:  state_d = IDLE;
      endcase
      // the transfer takes effect on the edge that enters RESP, so a following read sees the write
      commit = (state_q != RESP) && (state_d == RESP);
      data_d = (commit && !wr_d) ? mem[idx_d] : data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && commit && wr_d) mem[idx_d] <= wdata_d;
   end

   assign data_out_mem = data_q;
   assign ready_mem    = (state_q == RESP);
   assign busy         = (state_q != IDLE);

`ifdef MAIN_MEM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q + 16'(commit && !wr_d);
      wr_count_d = wr_count_q + 16'(commit && wr_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_main_memory_model.sv
// tb_main_memory_model: scoreboard bench for main_memory_model; expected refill data and latency come from a line model.
module tb_main_memory_model;
   localparam int LAT = 4;

   logic         clk = 1'b0, rst = 1'b0, read_en_mem = 1'b0, write_en_mem = 1'b0;
   logic [31:0]  address = '0;
   logic [127:0] dirty_block_in = '0, data_out_mem;
   logic         ready_mem, busy;
`ifdef MAIN_MEM_STATS_EN
   logic [15:0]  rd_count, wr_count;
`endif

   int           n_cmp = 0, n_fail = 0;
   logic [127:0] model [256];
   logic [127:0] last_rd = '0;
   logic [127:0] sb [$];

   main_memory_model #(.BLOCK_SIZE(128), .NUM_LINES(256), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
      .address(address), .dirty_block_in(dirty_block_in), .data_out_mem(data_out_mem),
      .ready_mem(ready_mem), .busy(busy)
`ifdef MAIN_MEM_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   // drive a request and push the data_out_mem value expected at its ready_mem pulse
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] d);
      @(negedge clk);
      read_en_mem = rd; write_en_mem = wr; address = a; dirty_block_in = d;
      if (wr) model[a[11:4]] = d;
      else last_rd = model[a[11:4]];
      sb.push_back(last_rd);
   endtask

   task automatic wait_ready(output int lat, output logic b1);
      lat = -1; b1 = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) b1 = busy;
         if (ready_mem) begin lat = k; break; end
      end
   endtask

   task automatic release_req();
      read_en_mem = 1'b0; write_en_mem = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (ready_mem !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_mem); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (data_out_mem !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out_mem); end
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic b1; logic [127:0] exp;
      issue(1'b0, 1'b1, 32'h40, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
      wait_ready(lat, b1);
      n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", b1); end
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL wr_dout_held: got %h want %h", data_out_mem, exp); end
      release_req();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_back_idle: got %b want 0", busy); end
      issue(1'b1, 1'b0, 32'h48, '0);
      wait_ready(lat, b1);
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL rd_offset_ignored: got %h want %h", data_out_mem, exp); end
      release_req();
   endtask

   task automatic test_hold();
      int lat, pulses; logic b1; logic [127:0] exp;
      pulses = 0;
      issue(1'b1, 1'b0, 32'h40, '0);
      wait_ready(lat, b1);
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL hold_data: got %h want %h", data_out_mem, exp); end
      repeat (3) begin @(negedge clk); if (ready_mem) pulses++; end
      n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL hold_extra_pulse: got %0d want 0", pulses); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
      read_en_mem = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_idle: got %b want 0", busy); end
      issue(1'b1, 1'b0, 32'h40, '0);
      wait_ready(lat, b1);
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL hold_reaccept_latency: got %0d want %0d", lat, LAT); end
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL hold_reaccept_data: got %h want %h", data_out_mem, exp); end
      release_req();
   endtask

   task automatic test_both();
      int lat; logic b1; logic [127:0] exp;
      issue(1'b1, 1'b1, 32'h100, 128'h1);
      wait_ready(lat, b1);
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL both_latency: got %0d want %0d", lat, LAT); end
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL both_dout_held: got %h want %h", data_out_mem, exp); end
      release_req();
      issue(1'b1, 1'b0, 32'h100, '0);
      wait_ready(lat, b1);
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL both_write_won: got %h want %h", data_out_mem, exp); end
      release_req();
   endtask

   task automatic test_reset_abort();
      int lat; logic b1; logic [127:0] exp;
      @(negedge clk);
      write_en_mem = 1'b1; address = 32'h200; dirty_block_in = '1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (ready_mem !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ready_mem); end
      n_cmp++; if (data_out_mem !== '0) begin n_fail++; $display("FAIL abort_data: got %h want 0", data_out_mem); end
      @(negedge clk);
      write_en_mem = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      last_rd = '0;
      issue(1'b1, 1'b0, 32'h200, '0);
      wait_ready(lat, b1);
      exp = sb.pop_front();
      n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL abort_not_committed: got %h want %h", data_out_mem, exp); end
      release_req();
   endtask

   task automatic test_back_to_back();
      int lat; logic b1; logic [127:0] exp;
      for (int i = 0; i < 8; i++) begin
         issue(i >= 4, i < 4, 32'h0001_0500 + 32'(i % 4) * 16, {$urandom, $urandom, $urandom, $urandom});
         wait_ready(lat, b1);
         n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, LAT); end
         exp = sb.pop_front();
         n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data_out_mem, exp); end
         release_req();
      end
   endtask

`ifdef MAIN_MEM_STATS_EN
   task automatic test_stats();
      int lat; logic b1; logic [127:0] exp;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1; last_rd = '0;
      n_cmp++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d want 0/0", rd_count, wr_count); end
      for (int i = 0; i < 5; i++) begin
         issue(i < 3, i >= 3, 32'h40, 128'(i + 7));
         wait_ready(lat, b1);
         exp = sb.pop_front();
         n_cmp++; if (data_out_mem !== exp) begin n_fail++; $display("FAIL stats_data[%0d]: got %h want %h", i, data_out_mem, exp); end
         release_req();
      end
      n_cmp++; if (rd_count !== 16'd3) begin n_fail++; $display("FAIL stats_rd: got %0d want 3", rd_count); end
      n_cmp++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL stats_wr: got %0d want 2", wr_count); end
   endtask
`endif

   initial begin
      foreach (model[i]) model[i] = '0;
      test_reset();
      test_write_read();
      test_hold();
      test_both();
      test_reset_abort();
      test_back_to_back();
`ifdef MAIN_MEM_STATS_EN
      test_stats();
`endif
      n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
